// File: rtl/char_generator_if.sv
// char_generator_if: output bundle of the falling-character generator.
//   ch    : ASCII code of the generated character ('A'..'Z')
//   speed : fall speed in pixels per move step (1..7)
//   x     : initial vertical pixel offset (row), 0..63
//   y     : horizontal pixel column of the character slot
// The generator drives the master modport and consumers use the slave modport.
interface char_generator_if;
  logic [7:0] ch;
  logic [2:0] speed;
  logic [8:0] x;
  logic [9:0] y;

  modport master (output ch, output speed, output x, output y);
  modport slave  (input  ch, input  speed, input  x, input  y);
endinterface

// File: rtl/char_generator.sv
// char_generator: pseudo-random falling-character source.
// A 16-bit Galois LFSR advances on every clk edge. Each edge produces a new
// character, speed, start row and column slot, all registered from the
// advanced LFSR value so they appear with no extra latency.
// Ports:
//   clk    : generation clock (one character per edge)
//   rst    : asynchronous active-high reset, restarts the sequence from SEED
//   out_if : char_generator_if.master carrying ch / speed / x / y
// Parameters:
//   SEED   : LFSR reset value (nonzero)
//   SLOT_W : pixel width of one column slot
//   SLOTS  : number of column slots (SLOTS*SLOT_W <= 640)
module char_generator #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int unsigned SLOT_W = 12,
  parameter int unsigned SLOTS  = 53
) (
  input  logic             clk,
  input  logic             rst,
  char_generator_if.master out_if
);

  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned SLOT_BW = 8;
  localparam int unsigned ALPHA_N = 26;
  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

  // Elaboration-time parameter sanity.
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("char_generator: SEED must be nonzero");
  end
  if (SLOTS == 0 || SLOT_W == 0 || SLOTS * SLOT_W > 640) begin : g_bad_slots
    $error("char_generator: SLOTS*SLOT_W must be in 1..640");
  end

  // Constant-divisor remainder of an 8-bit value: restoring subtraction
  // against shifted copies of the divisor, unrolled into pure combinational
  // compare/subtract stages.
  function automatic logic [7:0] mod_const(input logic [7:0] v,
                                           input int unsigned d);
    logic [23:0] r;
    logic [23:0] dd;
    r = 24'(v);
    for (int k = 7; k >= 0; k--) begin
      dd = 24'(d) << k;
      if (r >= dd) r = r - dd;
    end
    return 8'(r);
  endfunction

  logic [LFSR_W-1:0]  lfsr_q;
  logic [LFSR_W-1:0]  lfsr_n;
  logic [SLOT_BW-1:0] prev_slot_q;
  logic [SLOT_BW-1:0] slot_raw;
  logic [SLOT_BW-1:0] slot_n;
  logic [7:0]         ch_q,    ch_n;
  logic [2:0]         speed_q, speed_n;
  logic [8:0]         x_q,     x_n;
  logic [9:0]         y_q,     y_n;

  // Galois step; bit 0 feeds back onto the tap positions.
  always_comb begin
    lfsr_n = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_n = lfsr_n ^ TAPS;
  end

  // Output fields derived from the advanced LFSR value.
  always_comb begin
    ch_n     = 8'h41 + mod_const(lfsr_n[7:0], ALPHA_N);
    speed_n  = lfsr_n[2:0];
    if (lfsr_n[2:0] == 3'd0) speed_n = 3'd1;
    x_n      = {3'b000, lfsr_n[11:6]};
    slot_raw = mod_const(lfsr_n[15:8], SLOTS);
    slot_n   = slot_raw;
    // Bump to the neighbouring slot so consecutive characters never share
    // a column; the last slot wraps to slot 0.
    if (slot_raw == prev_slot_q) begin
      if (32'(slot_raw) == SLOTS - 1) slot_n = '0;
      else                            slot_n = slot_raw + 8'd1;
    end
    y_n      = 10'(32'(slot_n) * SLOT_W);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= SEED;
      prev_slot_q <= '0;
      ch_q        <= 8'h41;
      speed_q     <= 3'd1;
      x_q         <= 9'd0;
      y_q         <= 10'd0;
    end else begin
      lfsr_q      <= lfsr_n;
      prev_slot_q <= slot_n;
      ch_q        <= ch_n;
      speed_q     <= speed_n;
      x_q         <= x_n;
      y_q         <= y_n;
    end
  end

  assign out_if.ch    = ch_q;
  assign out_if.speed = speed_q;
  assign out_if.x     = x_q;
  assign out_if.y     = y_q;

endmodule

// File: tb/tb_char_generator.sv
// tb_char_generator: directed vector table for the reset/first-edge sequence
// and a mid-run asynchronous reset, two seeded instances that land on the
// slot-collision cases (plain bump and 52 -> 0 wrap), then a long run that
// compares every edge against a reference model and checks output ranges
// and the LFSR period.
module tb_char_generator;

  typedef struct {
    bit         do_rst;
    logic [7:0] ch;
    logic [2:0] speed;
    logic [8:0] x;
    logic [9:0] y;
  } vec_t;

  localparam int unsigned N_VEC    = 10;
  localparam int unsigned RUN_LEN  = 70000;
  localparam int unsigned PERIOD   = 65535;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic clk;
  logic rst;
  logic rst_aux;

  int checks;
  int errors;

  char_generator_if bus_main ();
  char_generator_if bus_bump ();
  char_generator_if bus_wrap ();

  char_generator #(.SEED(SEED), .SLOT_W(12), .SLOTS(53)) dut (
    .clk(clk), .rst(rst), .out_if(bus_main)
  );
  // next(6A00) = 3500: raw slot 53 mod 53 = 0 collides with reset slot 0.
  char_generator #(.SEED(16'h6A00), .SLOT_W(12), .SLOTS(53)) dut_bump (
    .clk(clk), .rst(rst_aux), .out_if(bus_bump)
  );
  // next(D200) = 6900 (slot 52), then 3480: raw slot 52 again -> wraps to 0.
  char_generator #(.SEED(16'hD200), .SLOT_W(12), .SLOTS(53)) dut_wrap (
    .clk(clk), .rst(rst_aux), .out_if(bus_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] ch,
                           input logic [2:0] sp, input logic [8:0] x,
                           input logic [9:0] y, input vec_t e);
    check({name, ".ch"},    32'(ch), 32'(e.ch));
    check({name, ".speed"}, 32'(sp), 32'(e.speed));
    check({name, ".x"},     32'(x),  32'(e.x));
    check({name, ".y"},     32'(y),  32'(e.y));
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference outputs for LFSR value l with previous slot prev; returns slot.
  function automatic int model_out(input logic [15:0] l, input int prev,
                                   output logic [29:0] packed_out);
    int slot;
    logic [7:0] c;
    logic [2:0] s;
    slot = int'(l[15:8]) % 53;
    if (slot == prev) slot = (slot + 1) % 53;
    c = 8'h41 + 8'(int'(l[7:0]) % 26);
    s = (l[2:0] == 3'd0) ? 3'd1 : l[2:0];
    packed_out = {c, s, 3'b000, l[11:6], 10'(slot * 12)};
    return slot;
  endfunction

  initial begin
    vec_t vecs[N_VEC];
    vec_t e;
    logic [15:0] ml;
    int          mprev;
    logic [29:0] exp_p;
    logic [29:0] got_p;
    logic [9:0]  last_y;
    bit          ok;

    checks = 0;
    errors = 0;

    vecs[0] = '{1'b1, 8'h41, 3'd1, 9'd0,  10'd0};
    vecs[1] = '{1'b0, 8'h49, 3'd1, 9'd9,  10'd168};
    vecs[2] = '{1'b0, 8'h45, 3'd1, 9'd4,  10'd84};
    vecs[3] = '{1'b0, 8'h41, 3'd4, 9'd34, 10'd36};
    vecs[4] = '{1'b0, 8'h41, 3'd6, 9'd49, 10'd336};
    vecs[5] = '{1'b0, 8'h4E, 3'd7, 9'd56, 10'd168};
    vecs[6] = '{1'b0, 8'h54, 3'd3, 9'd12, 10'd240};
    vecs[7] = '{1'b1, 8'h41, 3'd1, 9'd0,  10'd0};
    vecs[8] = '{1'b0, 8'h49, 3'd1, 9'd9,  10'd168};
    vecs[9] = '{1'b0, 8'h45, 3'd1, 9'd4,  10'd84};

    rst     = 1'b1;
    rst_aux = 1'b1;
    #3;

    // Table: reset rows assert rst between edges and check with no clock edge.
    for (int i = 0; i < int'(N_VEC); i++) begin
      if (vecs[i].do_rst) begin
        rst = 1'b1;
        #2;
        check_out($sformatf("vec%0d_rst", i), bus_main.ch, bus_main.speed,
                  bus_main.x, bus_main.y, vecs[i]);
        check($sformatf("vec%0d_rst.lfsr", i), 32'(dut.lfsr_q), 32'(SEED));
        @(negedge clk);
        rst = 1'b0;
      end else begin
        edge_step();
        check_out($sformatf("vec%0d_edge", i), bus_main.ch, bus_main.speed,
                  bus_main.x, bus_main.y, vecs[i]);
      end
    end

    // Slot-collision corner cases on the seeded instances.
    e = '{1'b1, 8'h41, 3'd1, 9'd0, 10'd0};
    check_out("bump_rst", bus_bump.ch, bus_bump.speed, bus_bump.x, bus_bump.y, e);
    check_out("wrap_rst", bus_wrap.ch, bus_wrap.speed, bus_wrap.x, bus_wrap.y, e);
    @(negedge clk);
    rst_aux = 1'b0;
    edge_step();
    e = '{1'b0, 8'h41, 3'd1, 9'd20, 10'd12};
    check_out("bump_e1", bus_bump.ch, bus_bump.speed, bus_bump.x, bus_bump.y, e);
    e = '{1'b0, 8'h41, 3'd1, 9'd36, 10'd624};
    check_out("wrap_e1", bus_wrap.ch, bus_wrap.speed, bus_wrap.x, bus_wrap.y, e);
    edge_step();
    e = '{1'b0, 8'h59, 3'd1, 9'd18, 10'd0};
    check_out("wrap_e2", bus_wrap.ch, bus_wrap.speed, bus_wrap.x, bus_wrap.y, e);

    // Long run against the reference model.
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst    = 1'b0;
    ml     = SEED;
    mprev  = 0;
    last_y = 10'd0;
    for (int n = 1; n <= int'(RUN_LEN); n++) begin
      edge_step();
      ml    = model_next(ml);
      mprev = model_out(ml, mprev, exp_p);
      got_p = {bus_main.ch, bus_main.speed, bus_main.x, bus_main.y};
      check($sformatf("run%0d.model", n), 32'(got_p), 32'(exp_p));
      ok = (bus_main.ch >= 8'h41) && (bus_main.ch <= 8'h5A) &&
           (bus_main.speed != 3'd0) && (bus_main.x <= 9'd63) &&
           (bus_main.y <= 10'd624) && ((bus_main.y % 10'd12) == 10'd0) &&
           (bus_main.y != last_y) && (dut.lfsr_q != 16'h0000);
      check($sformatf("run%0d.invariants", n), 32'(ok), 32'd1);
      if (n < int'(PERIOD) && dut.lfsr_q == SEED)
        check($sformatf("run%0d.early_period", n), 32'(dut.lfsr_q), 32'(~SEED));
      if (n == int'(PERIOD))
        check("period_returns_to_seed", 32'(dut.lfsr_q), 32'(SEED));
      last_y = bus_main.y;
      if (errors > 50) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
